// File: rtl/amo_sequencer.sv
// RV32A atomic-memory-operation sequencer: read, AMOALU combine, write back, return old word.
// Optional LR/SC reservation support is enabled by defining AMO_LRSC_EN.
module amo_sequencer (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        io_req_valid,
   output logic        io_req_ready,
   input  logic [4:0]  io_req_cmd,
   input  logic [31:0] io_req_addr,
   input  logic [31:0] io_req_data,
   output logic        io_resp_valid,
   output logic [31:0] io_resp_data,
   output logic        io_resp_error,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_req_write,
   output logic [31:0] mem_req_addr,
   output logic [31:0] mem_req_wdata,
   output logic [3:0]  mem_req_mask,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,
   output logic [4:0]  alu_cmd,
   output logic [3:0]  alu_mask,
   output logic [31:0] alu_lhs,
   output logic [31:0] alu_rhs,
   input  logic [31:0] alu_out
);

   localparam logic [4:0] CMD_SWAP = 5'h04;
   localparam logic [4:0] CMD_LR   = 5'h06;
   localparam logic [4:0] CMD_SC   = 5'h07;
   localparam logic [4:0] CMD_ADD  = 5'h08;
   localparam logic [4:0] CMD_XOR  = 5'h09;
   localparam logic [4:0] CMD_OR   = 5'h0a;
   localparam logic [4:0] CMD_AND  = 5'h0b;
   localparam logic [4:0] CMD_MIN  = 5'h0c;
   localparam logic [4:0] CMD_MAX  = 5'h0d;
   localparam logic [4:0] CMD_MINU = 5'h0e;
   localparam logic [4:0] CMD_MAXU = 5'h0f;

   typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP} state_t;

   state_t      state;
   logic [4:0]  cmd_q;
   logic [31:0] data_q;
   logic [31:0] old_q;
   logic        cmd_legal;

`ifdef AMO_LRSC_EN
   logic        rsv_valid;
   logic [29:0] rsv_addr;
   logic        rsv_hit;

   assign rsv_hit = rsv_valid && (rsv_addr == io_req_addr[31:2]);
`endif

   assign mem_req_mask = 4'hf;
   assign alu_mask     = 4'hf;
   assign alu_cmd      = cmd_q;
   assign alu_rhs      = data_q;
   assign alu_lhs      = old_q;

   always_comb begin
      cmd_legal = 1'b0;
      case (io_req_cmd)
         CMD_SWAP, CMD_ADD, CMD_XOR, CMD_OR, CMD_AND,
         CMD_MIN, CMD_MAX, CMD_MINU, CMD_MAXU: cmd_legal = 1'b1;
`ifdef AMO_LRSC_EN
         CMD_LR, CMD_SC:                       cmd_legal = 1'b1;
`endif
         default:                              cmd_legal = 1'b0;
      endcase
   end

   // Write data must follow alu_out in the same cycle, since old_q only settles on entry to WR_REQ.
   always_comb begin
      mem_req_wdata = '0;
      if (state == WR_REQ)
         mem_req_wdata = (cmd_q == CMD_SWAP || cmd_q == CMD_SC) ? data_q : alu_out;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         io_req_ready  <= 1'b1;
         io_resp_valid <= 1'b0;
         io_resp_data  <= '0;
         io_resp_error <= 1'b0;
         mem_req_valid <= 1'b0;
         mem_req_write <= 1'b0;
         mem_req_addr  <= '0;
         cmd_q         <= '0;
         data_q        <= '0;
         old_q         <= '0;
`ifdef AMO_LRSC_EN
         rsv_valid     <= 1'b0;
         rsv_addr      <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (io_req_valid) begin
                  cmd_q        <= io_req_cmd;
                  data_q       <= io_req_data;
                  mem_req_addr <= {io_req_addr[31:2], 2'b00};
                  io_req_ready <= 1'b0;
`ifdef AMO_LRSC_EN
                  if (io_req_cmd == CMD_SC)
                     rsv_valid <= 1'b0;
`endif
                  if (io_req_addr[1:0] != 2'b00 || !cmd_legal) begin
                     state         <= RESP;
                     io_resp_valid <= 1'b1;
                     io_resp_error <= 1'b1;
                     io_resp_data  <= '0;
                  end
`ifdef AMO_LRSC_EN
                  else if (io_req_cmd == CMD_SC) begin
                     if (rsv_hit) begin
                        state         <= WR_REQ;
                        mem_req_valid <= 1'b1;
                        mem_req_write <= 1'b1;
                     end else begin
                        state         <= RESP;
                        io_resp_valid <= 1'b1;
                        io_resp_data  <= 32'd1;
                     end
                  end
`endif
                  else begin
                     state         <= RD_REQ;
                     mem_req_valid <= 1'b1;
                     mem_req_write <= 1'b0;
                  end
               end
            end
            RD_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state         <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (mem_resp_valid) begin
                  old_q <= mem_resp_data;
                  if (cmd_q == CMD_LR) begin
                     state         <= RESP;
                     io_resp_valid <= 1'b1;
                     io_resp_data  <= mem_resp_data;
`ifdef AMO_LRSC_EN
                     rsv_valid     <= 1'b1;
                     rsv_addr      <= mem_req_addr[31:2];
`endif
                  end else begin
                     state         <= WR_REQ;
                     mem_req_valid <= 1'b1;
                     mem_req_write <= 1'b1;
                  end
               end
            end
            WR_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  mem_req_write <= 1'b0;
                  state         <= RESP;
                  io_resp_valid <= 1'b1;
                  io_resp_data  <= (cmd_q == CMD_SC) ? '0 : old_q;
`ifdef AMO_LRSC_EN
                  if (cmd_q != CMD_SC && rsv_valid && rsv_addr == mem_req_addr[31:2])
                     rsv_valid <= 1'b0;
`endif
               end
            end
            RESP: begin
               io_resp_valid <= 1'b0;
               io_resp_data  <= '0;
               io_resp_error <= 1'b0;
               io_req_ready  <= 1'b1;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
